// File: rtl/xs3_bcd_word_converter.sv
// xs3_bcd_word_converter
//   Converts a DIGITS-wide word between Excess-3 and BCD, one nibble per
//   clock. A word is captured in a single cycle and converted in place by a
//   counter-driven FSM. The converted word and a sticky error flag are then
//   held until downstream accepts them.
//
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     in_valid/in_ready   input handshake; in_ready is high only in IDLE
//     in_data, in_mode    source word (digit 0 = [3:0]); 0: XS3->BCD, 1: BCD->XS3
//     out_valid/out_ready output handshake; out_valid is high only in DONE
//     out_data, out_err   converted word; at least one source digit was invalid
//     err_pos             (XS3_BCD_ERR_POS_EN only) index of the lowest invalid digit
//
//   Optional feature macro: XS3_BCD_ERR_POS_EN adds the err_pos output.

module xs3_bcd_digit (
  input  logic       mode,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       bad
);
  // Conversion wraps modulo 16 even for invalid codes.
  always_comb begin
    if (mode) begin
      q   = d + 4'd3;
      bad = (d > 4'd9);
    end else begin
      q   = d - 4'd3;
      bad = (d < 4'd3) || (d > 4'd12);
    end
  end
endmodule

module xs3_bcd_word_converter #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = $clog2(DIGITS) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_data,
  input  logic                in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_data,
  output logic                out_err
`ifdef XS3_BCD_ERR_POS_EN
  ,
  output logic [CNT_W-1:0]    err_pos
`endif
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [4*DIGITS-1:0] word_q;
  logic                mode_q;
  logic                err_q;

  logic [3:0]          d_cur, d_new;
  logic                d_bad;
  logic [4*DIGITS-1:0] word_conv;
  logic                last;

  assign last = (cnt_q == CNT_W'(DIGITS - 1));

  // Pick the current digit and splice its converted value back in place.
  always_comb begin
    d_cur     = '0;
    word_conv = word_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        d_cur             = word_q[i*4 +: 4];
        word_conv[i*4 +: 4] = d_new;
      end
    end
  end

  xs3_bcd_digit u_digit (
    .mode (mode_q),
    .d    (d_cur),
    .q    (d_new),
    .bad  (d_bad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CONV;
      end
      CONV: if (last) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // out_data/out_err are separate from the working word so they only change
  // when a finished word is published, and hold after it is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      word_q   <= '0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          word_q <= in_data;
          mode_q <= in_mode;
          cnt_q  <= '0;
          err_q  <= 1'b0;
        end
        CONV: begin
          word_q <= word_conv;
          cnt_q  <= cnt_q + 1'b1;
          err_q  <= err_q | d_bad;
          if (last) begin
            out_data <= word_conv;
            out_err  <= err_q | d_bad;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef XS3_BCD_ERR_POS_EN
  // Digits are visited lowest first, so the first error seen is the lowest.
  logic [CNT_W-1:0] pos_q;
  logic             first_bad;

  assign first_bad = d_bad && !err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q   <= '0;
      err_pos <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) pos_q <= '0;
        CONV: begin
          if (first_bad) pos_q <= cnt_q;
          if (last) err_pos <= first_bad ? cnt_q : pos_q;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_xs3_bcd_word_converter.sv
module tb_xs3_bcd_word_converter;
  localparam int DIGITS = 4;
  localparam int CNT_W  = $clog2(DIGITS) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_err;
`ifdef XS3_BCD_ERR_POS_EN
  logic [CNT_W-1:0] err_pos;
`endif

  xs3_bcd_word_converter #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
`ifdef XS3_BCD_ERR_POS_EN
    ,
    .err_pos   (err_pos)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      din;
    logic             mode;
    logic [15:0]      dout;
    logic             err;
    logic [CNT_W-1:0] pos;
  } vec_t;

  typedef struct {
    logic [15:0]      d;
    logic             e;
    logic [CNT_W-1:0] p;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input logic e, input logic [CNT_W-1:0] p);
    exp_t x;
    x.d = d; x.e = e; x.p = p;
    sb.push_back(x);
  endtask

  // Wait for out_valid (bounded), check latency, compare against scoreboard.
  task automatic wait_and_check(input string tag);
    int   lat;
    exp_t x;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, lat, DIGITS);
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 1, 0);
    end else begin
      x = sb.pop_front();
      chk({tag, " out_data"}, out_data, x.d);
      chk({tag, " out_err"}, out_err, x.e);
`ifdef XS3_BCD_ERR_POS_EN
      chk({tag, " err_pos"}, err_pos, x.p);
`endif
    end
  endtask

  // Accept a word; while busy keep in_valid high with junk to show it is ignored.
  task automatic send(input vec_t v, input string tag);
    @(negedge clk);
    in_valid = 1'b1; in_data = v.din; in_mode = v.mode;
    push_exp(v.dout, v.err, v.pos);
    @(posedge clk); #1;
    chk({tag, " busy after accept"}, in_ready, 1'b0);
    in_data = 16'($urandom); in_mode = ~v.mode;
    wait_and_check(tag);
  endtask

  task automatic release_out(input string tag);
    logic [15:0] held;
    held = out_data;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({tag, " out_valid dropped"}, out_valid, 1'b0);
    chk({tag, " out_data held"}, out_data, held);
  endtask

  vec_t tbl[8];
  vec_t v;
  logic stable, seen;
  logic [15:0] snap;

  initial begin
    tbl[0] = '{16'h3456, 1'b0, 16'h0123, 1'b0, 0};
    tbl[1] = '{16'h9870, 1'b1, 16'hCBA3, 1'b0, 0};
    tbl[2] = '{16'hCBA3, 1'b0, 16'h9870, 1'b0, 0};
    tbl[3] = '{16'h3F41, 1'b0, 16'h0C1E, 1'b1, 0};
    tbl[4] = '{16'hA123, 1'b1, 16'hD456, 1'b1, 3};
    tbl[5] = '{16'hCCCC, 1'b0, 16'h9999, 1'b0, 0};
    tbl[6] = '{16'h0000, 1'b1, 16'h3333, 1'b0, 0};
    tbl[7] = '{16'h2C33, 1'b0, 16'hF900, 1'b1, 3};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset out_data", out_data, 16'h0000);
    chk("reset out_err", out_err, 1'b0);
    rst = 1'b0;

    // Mid-cycle async reset while a word sits in DONE
    send(tbl[0], "pre-reset");
    @(negedge clk); #2 rst = 1'b1; #1;
    chk("async in_ready", in_ready, 1'b1);
    chk("async out_valid", out_valid, 1'b0);
    chk("async out_data", out_data, 16'h0000);
    chk("async out_err", out_err, 1'b0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      send(tbl[i], $sformatf("vec%0d", i));
      release_out($sformatf("vec%0d", i));
    end

    // Back-pressure for 10 cycles, then transfer with in_valid raised together
    v = tbl[0];
    send(v, "bp");
    snap = out_data; stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!out_valid || out_data !== snap || in_ready) stable = 1'b0;
    end
    chk("bp stable", stable, 1'b1);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h9870; in_mode = 1'b1;
    push_exp(16'hCBA3, 1'b0, 0);
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp transfer out_valid", out_valid, 1'b0);
    chk("bp not accepted same cycle", in_ready, 1'b1);
    @(posedge clk); #1;
    chk("bp accepted next cycle", in_ready, 1'b0);
    wait_and_check("bp next");
    release_out("bp next");

    // Abort two cycles into CONV
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h1234; in_mode = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2 rst = 1'b1; #1;
    chk("abort in_ready", in_ready, 1'b1);
    chk("abort out_valid", out_valid, 1'b0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort no output", seen, 1'b0);
    v = '{16'h3333, 1'b0, 16'h0000, 1'b0, 0};
    send(v, "post-abort");
    release_out("post-abort");

    chk("scoreboard drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xs3_bcd_word_converter.md
Name: xs3_bcd_word_converter

Overview:
- Multi-digit, bidirectional Excess-3 and BCD code converter with valid/ready handshakes on both sides.
- A whole DIGITS-wide word is captured in one cycle, then converted serially, one nibble per clock, by a counter-driven FSM.
- Any invalid code digit raises a sticky error flag for that word.
- Sits between the numeric front-end and the BCD display/arithmetic datapaths; it replaces the single-digit combinational XS3-to-BCD decoder.

Parameters:
- DIGITS, 4, number of 4-bit digits per word; legal range 1..16.
- CNT_W, $clog2(DIGITS)+1, digit counter width; derived, do not override.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, in_data and in_mode are valid.
- in_ready, output, 1, converter can accept a word.
- in_data, input, 4*DIGITS, source word; digit 0 is in_data[3:0].
- in_mode, input, 1, 0 selects XS3->BCD, 1 selects BCD->XS3.
- out_valid, output, 1, converted word available.
- out_ready, input, 1, downstream accepts the word.
- out_data, output, 4*DIGITS, converted word, same digit order as in_data.
- out_err, output, 1, at least one source digit was an invalid code.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, digit counter=0, word and mode registers=0.
  - in_ready=1, out_valid=0, out_data=0, out_err=0.
  - Reset asserted mid-conversion or in DONE aborts the word; it is discarded and not output.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: capture in_data into the word register and in_mode into the mode register, clear counter and error, go to CONV.
- CONV:
  - in_ready=0, out_valid=0.
  - Each edge converts digit[cnt] in place and increments cnt.
  - When cnt reaches DIGITS-1 on that edge, go to DONE.
  - Total: DIGITS edges in CONV.
- Latency: out_valid rises exactly DIGITS cycles after the accept edge. For DIGITS=1, CONV lasts one cycle.
- Per-digit arithmetic (4-bit, modulo 16):
  - Mode 0: d_out = d_in - 3. d_in of 0, 1, 2, 13, 14 or 15 is invalid.
  - Mode 1: d_out = d_in + 3. d_in of 10..15 is invalid.
  - Invalid digits are still converted modulo 16 and set the sticky error bit.
- DONE:
  - out_valid=1; out_data and out_err held stable while out_ready=0 (back-pressure of any length).
  - On an edge with out_ready=1: go to IDLE, out_valid=0. out_data holds its last value.
  - in_ready is 0 in DONE, so a word cannot be accepted in the same cycle the output is taken.
- Input changes to in_data and in_mode after the accept edge have no effect.
- in_valid is ignored whenever in_ready=0.

Optional Feature:
- Macro: XS3_BCD_ERR_POS_EN.
- Defined:
  - Adds output err_pos, width CNT_W: the index of the lowest invalid digit in the word, valid while out_valid=1 and out_err=1.
  - err_pos is 0 when out_err=0 and resets to 0.
- Undefined: port absent, no extra logic; all other behaviour identical.

Test Plan:
- Reset then idle: assert rst asynchronously mid-cycle -> in_ready=1, out_valid=0, out_data=16'h0000 and out_err=0 immediately, without waiting for a clock edge.
- DIGITS=4, mode 0, in_data=16'h3456 accepted at edge k -> out_valid=1 after edge k+4, out_data=16'h0123, out_err=0.
- DIGITS=4, mode 1, in_data=16'h9870 -> out_data=16'hCBA3, out_err=0. Round-trip 16'hCBA3 in mode 0 -> 16'h9870.
- Invalid codes:
  - Mode 0, in_data=16'h3F41 -> out_err=1, out_data=16'h0C1E; with XS3_BCD_ERR_POS_EN, err_pos=0.
  - Mode 1, in_data=16'hA123 -> out_err=1, out_data=16'hD456, err_pos=3.
- Back-pressure and re-accept: hold out_ready=0 for 10 cycles -> out_valid and out_data stable, in_ready=0. Raise out_ready together with in_valid for the next word -> that word is accepted one cycle after the output transfer, not the same cycle.
- Abort: assert rst two cycles into CONV -> state IDLE, out_valid never asserts for that word. The next word, 16'h3333 in mode 0, yields 16'h0000.
